// File: rtl/tohost_monitor.sv
// tohost_monitor: end-of-test responder on the core's data-memory write port.
// Watches for full-word stores to TOHOST_ADDR and latches a sticky verdict:
// PASS (value 1), FAIL (odd value != 1, test number in bits [31:1]) or TIMEOUT
// (no verdict within TIMEOUT_CYCLES run cycles). A one-cycle done pulse marks
// entry into any terminal state.
//
// Handshake: dmem_we is a fire-and-forget strobe with no ready. Every cycle
// it is high carries exactly one store, and the monitor never stalls the core.
// retire is likewise a plain per-cycle event strobe.
module tohost_monitor #(
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             dmem_we,
    input  logic [31:0]      dmem_addr,
    input  logic [31:0]      dmem_wdata,
    input  logic [3:0]       dmem_be,
    input  logic             retire,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic             proto_err,
    output logic [30:0]      test_num,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count
);

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_PASS    = 2'd1;
    localparam logic [1:0] S_FAIL    = 2'd2;
    localparam logic [1:0] S_TIMEOUT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             timeout_q, timeout_d;
    logic             proto_q, proto_d;
    logic [30:0]      test_num_q, test_num_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] retire_q, retire_d;

    logic hit;
    logic hit_pass;
    logic hit_fail;
    logic hit_proto;

    // Store decode: only full-word stores to the exact tohost address count.
    always_comb begin
        hit       = dmem_we && (dmem_addr == TOHOST_ADDR) && (dmem_be == 4'b1111);
        hit_pass  = hit && (dmem_wdata == 32'd1);
        hit_fail  = hit && dmem_wdata[0] && (dmem_wdata != 32'd1);
        hit_proto = hit && !dmem_wdata[0] && (dmem_wdata != 32'd0);
    end

    // Next-state: clear beats everything, a verdict store beats timeout,
    // terminal states hold every output until clear or reset.
    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        fail_d     = fail_q;
        timeout_d  = timeout_q;
        proto_d    = proto_q;
        test_num_d = test_num_q;
        cycle_d    = cycle_q;
        retire_d   = retire_q;

        if (clear) begin
            state_d    = S_RUN;
            pass_d     = 1'b0;
            fail_d     = 1'b0;
            timeout_d  = 1'b0;
            proto_d    = 1'b0;
            test_num_d = '0;
            cycle_d    = '0;
            retire_d   = '0;
        end else if (state_q == S_RUN) begin
            if (retire) begin
                retire_d = retire_q + CNT_ONE;
            end
            if (hit_pass) begin
                // cycle_count freezes at the value seen on the verdict edge
                state_d = S_PASS;
                pass_d  = 1'b1;
                done_d  = 1'b1;
            end else if (hit_fail) begin
                state_d    = S_FAIL;
                fail_d     = 1'b1;
                test_num_d = dmem_wdata[31:1];
                done_d     = 1'b1;
            end else begin
                cycle_d = cycle_q + CNT_ONE;
                if (hit_proto) begin
                    proto_d = 1'b1;
                end
                if (cycle_q == CYC_LAST) begin
                    state_d   = S_TIMEOUT;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                end
            end
        end
    end

    // State and output registers, asynchronously cleared by rst low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_RUN;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            timeout_q  <= 1'b0;
            proto_q    <= 1'b0;
            test_num_q <= '0;
            cycle_q    <= '0;
            retire_q   <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            timeout_q  <= timeout_d;
            proto_q    <= proto_d;
            test_num_q <= test_num_d;
            cycle_q    <= cycle_d;
            retire_q   <= retire_d;
        end
    end

    assign done         = done_q;
    assign pass         = pass_q;
    assign fail         = fail_q;
    assign timeout      = timeout_q;
    assign proto_err    = proto_q;
    assign test_num     = test_num_q;
    assign cycle_count  = cycle_q;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_tohost_monitor.sv
// Testbench for tohost_monitor: two instances share one stimulus stream,
// u_long with the default timeout and u_short with TIMEOUT_CYCLES=50.
module tb_tohost_monitor;

    localparam logic [31:0] A  = 32'h0000_1000;
    localparam int          EW = 1 + 5 + 31 + 32 + 32;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        ret;
        logic        clr;
        logic        sel_short;
        logic [4:0]  fl;   // {done, pass, fail, timeout, proto_err}
        logic [30:0] tn;
        logic [31:0] cyc;
        logic [31:0] rc;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        clear = 1'b0;
    logic        dmem_we = 1'b0;
    logic [31:0] dmem_addr = '0;
    logic [31:0] dmem_wdata = '0;
    logic [3:0]  dmem_be = '0;
    logic        retire = 1'b0;

    logic        l_done, l_pass, l_fail, l_tmo, l_perr;
    logic [30:0] l_tn;
    logic [31:0] l_cyc, l_rc;
    logic        s_done, s_pass, s_fail, s_tmo, s_perr;
    logic [30:0] s_tn;
    logic [31:0] s_cyc, s_rc;

    tohost_monitor u_long (
        .clk(clk), .rst(rst), .clear(clear),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .retire(retire),
        .done(l_done), .pass(l_pass), .fail(l_fail), .timeout(l_tmo),
        .proto_err(l_perr), .test_num(l_tn), .cycle_count(l_cyc),
        .retire_count(l_rc)
    );

    tohost_monitor #(.TIMEOUT_CYCLES(50)) u_short (
        .clk(clk), .rst(rst), .clear(clear),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .retire(retire),
        .done(s_done), .pass(s_pass), .fail(s_fail), .timeout(s_tmo),
        .proto_err(s_perr), .test_num(s_tn), .cycle_count(s_cyc),
        .retire_count(s_rc)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                input logic ret, input logic clr, input logic sel,
                                input logic [4:0] fl, input logic [30:0] tn,
                                input logic [31:0] cyc, input logic [31:0] rc);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.ret = ret;
        v.clr = clr; v.sel_short = sel; v.fl = fl; v.tn = tn; v.cyc = cyc; v.rc = rc;
        return v;
    endfunction

    function automatic logic [EW-1:0] pack_exp(input vec_t v);
        return {v.sel_short, v.fl, v.tn, v.cyc, v.rc};
    endfunction

    task automatic compare(input string nm);
        logic [EW-1:0] e;
        logic [EW-2:0] act;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard queue empty", nm);
            return;
        end
        e = exp_q.pop_front();
        if (e[EW-1])
            act = {s_done, s_pass, s_fail, s_tmo, s_perr, s_tn, s_cyc, s_rc};
        else
            act = {l_done, l_pass, l_fail, l_tmo, l_perr, l_tn, l_cyc, l_rc};
        if (act !== e[EW-2:0]) begin
            errors++;
            $display("FAIL %s (%s): got flags=%b tn=%0d cyc=%0d ret=%0d, expected flags=%b tn=%0d cyc=%0d ret=%0d",
                     nm, e[EW-1] ? "short" : "long",
                     act[EW-2:EW-6], act[94:64], act[63:32], act[31:0],
                     e[EW-2:EW-6], e[94:64], e[63:32], e[31:0]);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive one cycle of stimulus, push its expectation, compare after the edge.
    task automatic apply(input vec_t v, input string nm);
        dmem_we    = v.we;
        dmem_addr  = v.addr;
        dmem_wdata = v.wdata;
        dmem_be    = v.be;
        retire     = v.ret;
        clear      = v.clr;
        exp_q.push_back(pack_exp(v));
        @(posedge clk);
        #1;
        compare(nm);
    endtask

    task automatic idle(input int n, input logic ret);
        dmem_we = 1'b0;
        clear   = 1'b0;
        retire  = ret;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compare current outputs without advancing the clock.
    task automatic check_now(input logic sel, input string nm);
        exp_q.push_back(pack_exp(mk(0, 0, 0, 0, 0, 0, sel, 5'b00000, '0, '0, '0)));
        compare(nm);
    endtask

    vec_t tbl[$];
    int   n_rand;
    int   tally;
    logic r_last;

    // ---------------- stimulus ----------------
    initial begin
        // Pass / fail / filtering / clear-race table, long-timeout instance.
        tbl.push_back(mk(1, A,     32'h1,         4'hf, 1, 0, 0, 5'b11000, 0, 100, 101));
        tbl.push_back(mk(0, A,     32'h1,         4'hf, 1, 0, 0, 5'b01000, 0, 100, 101));
        tbl.push_back(mk(1, A,     32'h7,         4'hf, 1, 0, 0, 5'b01000, 0, 100, 101));
        tbl.push_back(mk(1, A,     32'h1,         4'hf, 1, 1, 0, 5'b00000, 0, 0,   0));
        tbl.push_back(mk(0, A,     32'h0,         4'hf, 1, 0, 0, 5'b00000, 0, 1,   1));
        tbl.push_back(mk(1, A,     32'h7,         4'hf, 0, 0, 0, 5'b10100, 3, 1,   1));
        tbl.push_back(mk(0, A,     32'h0,         4'hf, 1, 0, 0, 5'b00100, 3, 1,   1));
        tbl.push_back(mk(1, A,     32'h1,         4'hf, 1, 0, 0, 5'b00100, 3, 1,   1));
        tbl.push_back(mk(0, A,     32'h0,         4'hf, 0, 1, 0, 5'b00000, 0, 0,   0));
        tbl.push_back(mk(1, A,     32'h1,         4'h3, 1, 0, 0, 5'b00000, 0, 1,   1));
        tbl.push_back(mk(1, A + 4, 32'h1,         4'hf, 0, 0, 0, 5'b00000, 0, 2,   1));
        tbl.push_back(mk(1, A + 1, 32'h1,         4'hf, 0, 0, 0, 5'b00000, 0, 3,   1));
        tbl.push_back(mk(0, A,     32'h1,         4'hf, 0, 0, 0, 5'b00000, 0, 4,   1));
        tbl.push_back(mk(1, A,     32'h0,         4'hf, 1, 0, 0, 5'b00000, 0, 5,   2));
        tbl.push_back(mk(1, A,     32'h4,         4'hf, 0, 0, 0, 5'b00001, 0, 6,   2));
        tbl.push_back(mk(1, A,     32'h8000_0000, 4'hf, 0, 0, 0, 5'b00001, 0, 7,   2));
        tbl.push_back(mk(1, A,     32'h1,         4'hf, 1, 0, 0, 5'b11001, 0, 7,   3));
        tbl.push_back(mk(0, A,     32'h0,         4'hf, 0, 0, 0, 5'b01001, 0, 7,   3));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_now(0, "reset_long");
        check_now(1, "reset_short");
        @(negedge clk);
        rst = 1'b1;

        idle(100, 1'b1);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("tbl%0d", i));
        end

        // Timeout on the 50th edge after reset release, retire held high.
        #2;
        rst = 1'b0;
        #1;
        check_now(1, "async_rst_short");
        @(negedge clk);
        rst = 1'b1;
        idle(48, 1'b1);
        apply(mk(0, A, 0, 4'hf, 1, 0, 1, 5'b00000, 0, 49, 49), "tmo_edge49");
        apply(mk(0, A, 0, 4'hf, 1, 0, 1, 5'b10010, 0, 50, 50), "tmo_edge50");
        apply(mk(0, A, 0, 4'hf, 1, 0, 1, 5'b00010, 0, 50, 50), "tmo_frozen");
        apply(mk(1, A, 1, 4'hf, 1, 0, 1, 5'b00010, 0, 50, 50), "tmo_absorb_pass");
        apply(mk(1, A, 7, 4'hf, 1, 0, 1, 5'b00010, 0, 50, 50), "tmo_absorb_fail");

        // Pass store on the timeout-expiry edge: the store wins.
        apply(mk(1, A, 1, 4'hf, 1, 1, 1, 5'b00000, 0, 0, 0), "race_clear");
        idle(48, 1'b0);
        apply(mk(0, A, 0, 4'hf, 0, 0, 1, 5'b00000, 0, 49, 0), "race_pre49");
        apply(mk(1, A, 1, 4'hf, 0, 0, 1, 5'b11000, 0, 49, 0), "race_pass_wins");
        apply(mk(0, A, 0, 4'hf, 0, 0, 1, 5'b01000, 0, 49, 0), "race_pass_hold");

        // Fail store on the timeout-expiry edge.
        apply(mk(0, A, 0, 4'hf, 0, 1, 1, 5'b00000, 0, 0, 0), "race2_clear");
        idle(48, 1'b0);
        apply(mk(0, A, 0, 4'hf, 0, 0, 1, 5'b00000, 0, 49, 0), "race2_pre49");
        apply(mk(1, A, 5, 4'hf, 0, 0, 1, 5'b10100, 2, 49, 0), "race2_fail_wins");
        apply(mk(0, A, 0, 4'hf, 0, 0, 1, 5'b00100, 2, 49, 0), "race2_fail_hold");

        // Async reset mid-cycle while in FAIL.
        apply(mk(0, A, 0, 4'hf, 0, 1, 0, 5'b00000, 0, 0, 0), "ar_clear");
        apply(mk(1, A, 7, 4'hf, 0, 0, 0, 5'b10100, 3, 0, 0), "ar_fail");
        #2;
        rst = 1'b0;
        #1;
        check_now(0, "ar_zero_long");
        check_now(1, "ar_zero_short");
        @(negedge clk);
        rst = 1'b1;
        apply(mk(1, A, 1, 4'hf, 0, 0, 0, 5'b11000, 0, 0, 0), "ar_then_pass");

        // Random retire pattern, then a pass store.
        apply(mk(0, A, 0, 4'hf, 0, 1, 0, 5'b00000, 0, 0, 0), "rnd_clear");
        n_rand = $urandom_range(20, 60);
        tally  = 0;
        clear   = 1'b0;
        dmem_we = 1'b0;
        for (int k = 0; k < n_rand; k++) begin
            retire = 1'($urandom_range(0, 1));
            if (retire) tally++;
            @(posedge clk);
            #1;
        end
        r_last = 1'($urandom_range(0, 1));
        apply(mk(1, A, 1, 4'hf, r_last, 0, 0, 5'b11000, 0, 32'(n_rand),
                 32'(tally) + 32'(r_last)), "rnd_pass");

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover: %0d expectations never compared", exp_q.size());
        end

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog: the run is a few hundred cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
